// File: rtl/offset_adjustment_arbiter.sv
// Arbitrates offset corrections from several time slaves onto the single
// adjustment input of the adjustable clock, with a guard interval after each pulse.
//
// state | meaning
// IDLE  | no adjustment in flight; grants the highest-priority pending slot
// ISSUE | granted adjustment is on the outputs, ValOut high for this cycle
// HOLD  | guard interval while the clock applies the correction
module offset_adjustment_arbiter #(
    parameter int NumSources_Gen = 3,
    parameter int HoldCycles_Gen = 16
) (
    input  logic                           SysClk_ClkIn,
    input  logic                           SysRstN_RstIn,
    input  logic [NumSources_Gen-1:0]      Enable_DatIn,
    input  logic                           ClockTime_TimeJump_DatIn,
    input  logic                           ClearStatus_EvtIn,
    input  logic [32*NumSources_Gen-1:0]   SrcOffset_Second_DatIn,
    input  logic [32*NumSources_Gen-1:0]   SrcOffset_Nanosecond_DatIn,
    input  logic [NumSources_Gen-1:0]      SrcOffset_Sign_DatIn,
    input  logic [32*NumSources_Gen-1:0]   SrcOffset_Interval_DatIn,
    input  logic [NumSources_Gen-1:0]      SrcOffset_ValIn,
    output logic [31:0]                    OffsetAdjustment_Second_DatOut,
    output logic [31:0]                    OffsetAdjustment_Nanosecond_DatOut,
    output logic                           OffsetAdjustment_Sign_DatOut,
    output logic [31:0]                    OffsetAdjustment_Interval_DatOut,
    output logic                           OffsetAdjustment_ValOut,
    output logic [1:0]                     Grant_DatOut,
    output logic [NumSources_Gen-1:0]      Overwrite_DatOut,
    output logic [NumSources_Gen-1:0]      Dropped_DatOut,
    output logic [31:0]                    IssueCount_DatOut
);
    localparam int HW = $clog2(HoldCycles_Gen + 1);
    localparam int N  = NumSources_Gen;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [N-1:0][31:0]  slot_sec_q, slot_sec_d;
    logic [N-1:0][31:0]  slot_ns_q, slot_ns_d;
    logic [N-1:0]        slot_sign_q, slot_sign_d;
    logic [N-1:0][31:0]  slot_intv_q, slot_intv_d;
    logic [31:0]         out_sec_q, out_sec_d;
    logic [31:0]         out_ns_q, out_ns_d;
    logic                out_sign_q, out_sign_d;
    logic [31:0]         out_intv_q, out_intv_d;
    logic                val_q, val_d;
    logic [1:0]          grant_q, grant_d;
    logic [N-1:0]        ovw_q, ovw_d;
    logic [N-1:0]        drop_q, drop_d;
    logic [31:0]         count_q, count_d;

    logic [N-1:0]        req;
    logic [N-1:0]        gnt_oh;
    logic [1:0]          gnt_idx;
    logic                gnt_any;
    logic                can_grant;
    logic                cap;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        slot_sec_d  = slot_sec_q;
        slot_ns_d   = slot_ns_q;
        slot_sign_d = slot_sign_q;
        slot_intv_d = slot_intv_q;
        out_sec_d   = out_sec_q;
        out_ns_d    = out_ns_q;
        out_sign_d  = out_sign_q;
        out_intv_d  = out_intv_q;
        val_d       = 1'b0;
        grant_d     = grant_q;
        count_d     = count_q;
        ovw_d       = ClearStatus_EvtIn ? '0 : ovw_q;
        drop_d      = ClearStatus_EvtIn ? '0 : drop_q;
        cap         = 1'b0;

        req     = pend_q & Enable_DatIn;
        gnt_oh  = '0;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt_any) begin
                gnt_any   = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_idx   = 2'(i);
            end
        end

        // A new grant may start from IDLE or straight out of the last HOLD cycle,
        // which keeps back-to-back pulses HoldCycles_Gen+1 cycles apart.
        can_grant = gnt_any && !ClockTime_TimeJump_DatIn &&
                    ((state_q == IDLE) || (state_q == HOLD && hold_q == HW'(1)));

        case (state_q)
            IDLE: if (can_grant) state_d = ISSUE;
            ISSUE: begin
                count_d = count_q + 32'd1;
                hold_d  = HW'(HoldCycles_Gen);
                state_d = HOLD;
            end
            HOLD: begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) state_d = can_grant ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (can_grant) begin
            val_d   = 1'b1;
            grant_d = gnt_idx;
            for (int i = 0; i < N; i++) begin
                if (gnt_oh[i]) begin
                    out_sec_d  = slot_sec_q[i];
                    out_ns_d   = slot_ns_q[i];
                    out_sign_d = slot_sign_q[i];
                    out_intv_d = slot_intv_q[i];
                end
            end
        end

        // Slot update order: flush, disable, capture (beats same-edge grant), grant.
        for (int i = 0; i < N; i++) begin
            cap = SrcOffset_ValIn[i] && Enable_DatIn[i];
            if (ClockTime_TimeJump_DatIn || !Enable_DatIn[i]) begin
                if (pend_q[i]) begin
                    pend_d[i] = 1'b0;
                    drop_d[i] = 1'b1;
                end
            end else if (cap) begin
                pend_d[i]      = 1'b1;
                slot_sec_d[i]  = SrcOffset_Second_DatIn[32*i +: 32];
                slot_ns_d[i]   = SrcOffset_Nanosecond_DatIn[32*i +: 32];
                slot_sign_d[i] = SrcOffset_Sign_DatIn[i];
                slot_intv_d[i] = SrcOffset_Interval_DatIn[32*i +: 32];
                if (pend_q[i] && !(can_grant && gnt_oh[i])) ovw_d[i] = 1'b1;
            end else if (can_grant && gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            pend_q      <= '0;
            slot_sec_q  <= '0;
            slot_ns_q   <= '0;
            slot_sign_q <= '0;
            slot_intv_q <= '0;
            out_sec_q   <= '0;
            out_ns_q    <= '0;
            out_sign_q  <= 1'b0;
            out_intv_q  <= '0;
            val_q       <= 1'b0;
            grant_q     <= '0;
            ovw_q       <= '0;
            drop_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            slot_sec_q  <= slot_sec_d;
            slot_ns_q   <= slot_ns_d;
            slot_sign_q <= slot_sign_d;
            slot_intv_q <= slot_intv_d;
            out_sec_q   <= out_sec_d;
            out_ns_q    <= out_ns_d;
            out_sign_q  <= out_sign_d;
            out_intv_q  <= out_intv_d;
            val_q       <= val_d;
            grant_q     <= grant_d;
            ovw_q       <= ovw_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
        end
    end

    assign OffsetAdjustment_Second_DatOut     = out_sec_q;
    assign OffsetAdjustment_Nanosecond_DatOut = out_ns_q;
    assign OffsetAdjustment_Sign_DatOut       = out_sign_q;
    assign OffsetAdjustment_Interval_DatOut   = out_intv_q;
    assign OffsetAdjustment_ValOut            = val_q;
    assign Grant_DatOut                       = grant_q;
    assign Overwrite_DatOut                   = ovw_q;
    assign Dropped_DatOut                     = drop_q;
    assign IssueCount_DatOut                  = count_q;
endmodule

// File: tb/tb_offset_adjustment_arbiter.sv
// Scoreboard bench for offset_adjustment_arbiter: expected adjustments are queued
// when requests are driven and checked against each ValOut pulse.
module tb_offset_adjustment_arbiter;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  en = '1;
    logic          tj = 1'b0;
    logic          clr = 1'b0;
    logic [32*N-1:0] sec_in = '0, ns_in = '0, intv_in = '0;
    logic [N-1:0]  sign_in = '0, val_in = '0;
    logic [31:0]   sec_out, ns_out, intv_out, cnt_out;
    logic          sign_out, val_out;
    logic [1:0]    grant_out;
    logic [N-1:0]  ovw_out, drop_out;

    offset_adjustment_arbiter #(.NumSources_Gen(N), .HoldCycles_Gen(16)) dut (
        .SysClk_ClkIn                       (clk),
        .SysRstN_RstIn                      (rst_n),
        .Enable_DatIn                       (en),
        .ClockTime_TimeJump_DatIn           (tj),
        .ClearStatus_EvtIn                  (clr),
        .SrcOffset_Second_DatIn             (sec_in),
        .SrcOffset_Nanosecond_DatIn         (ns_in),
        .SrcOffset_Sign_DatIn               (sign_in),
        .SrcOffset_Interval_DatIn           (intv_in),
        .SrcOffset_ValIn                    (val_in),
        .OffsetAdjustment_Second_DatOut     (sec_out),
        .OffsetAdjustment_Nanosecond_DatOut (ns_out),
        .OffsetAdjustment_Sign_DatOut       (sign_out),
        .OffsetAdjustment_Interval_DatOut   (intv_out),
        .OffsetAdjustment_ValOut            (val_out),
        .Grant_DatOut                       (grant_out),
        .Overwrite_DatOut                   (ovw_out),
        .Dropped_DatOut                     (drop_out),
        .IssueCount_DatOut                  (cnt_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sec;
        logic [31:0] ns;
        logic        sign;
        logic [31:0] intv;
        logic [1:0]  grant;
        logic [31:0] cnt;
        int          at_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_count = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] n, input logic sg,
                        input logic [31:0] iv, input logic [1:0] g, input int at);
        sb.push_back('{s, n, sg, iv, g, exp_count, at});
        exp_count++;
    endtask

    task automatic set_src(input int s, input logic [31:0] sc, input logic [31:0] n,
                           input logic sg, input logic [31:0] iv);
        sec_in[32*s +: 32]  = sc;
        ns_in[32*s +: 32]   = n;
        intv_in[32*s +: 32] = iv;
        sign_in[s]          = sg;
        val_in[s]           = 1'b1;
    endtask

    task automatic cyc_step();
        @(negedge clk);
        val_in = '0;
        tj     = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) cyc_step();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && val_out) begin
            if (sb.size() == 0) begin
                check("unexpected_val", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("adj_sec", sec_out, e.sec);
                check("adj_ns", ns_out, e.ns);
                check("adj_sign", sign_out, e.sign);
                check("adj_intv", intv_out, e.intv);
                check("adj_grant", grant_out, e.grant);
                check("adj_count", cnt_out, e.cnt);
                check("adj_cycle", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_val", val_out, 0);
        check("rst_grant", grant_out, 0);
        check("rst_count", cnt_out, 0);
        check("rst_ovw", ovw_out, 0);
        check("rst_drop", drop_out, 0);
        rst_n = 1'b1;
        settle(2);

        // Single request: latency and field routing
        cyc_step(); set_src(1, 0, 250, 1, 1000); c = cyc; push(0, 250, 1, 1000, 1, c + 2);
        cyc_step(); drain(); settle(20);
        check("count_single", cnt_out, 1);

        // Priority: 0 before 2, second one 17 cycles later
        cyc_step(); set_src(0, 5, 10, 0, 20); set_src(2, 6, 30, 1, 40); c = cyc;
        push(5, 10, 0, 20, 0, c + 2); push(6, 30, 1, 40, 2, c + 19);
        cyc_step(); drain(); settle(20);
        check("count_prio", cnt_out, 3);

        // Overwrite during HOLD: latest wins
        cyc_step(); set_src(0, 1, 1, 0, 1); c = cyc; push(1, 1, 0, 1, 0, c + 2);
        cyc_step(); settle(3);
        set_src(2, 0, 100, 0, 7); cyc_step();
        set_src(2, 0, 200, 0, 7); push(0, 200, 0, 7, 2, c + 19);
        cyc_step(); drain(); settle(20);
        check("ovw_set", ovw_out, 3'b100);
        clr = 1'b1; cyc_step();
        check("ovw_clr", ovw_out, 0);

        // Time jump flushes pending slots; current HOLD still completes
        cyc_step(); set_src(0, 2, 2, 1, 2); c = cyc; push(2, 2, 1, 2, 0, c + 2);
        cyc_step(); settle(3);
        set_src(1, 3, 3, 0, 3); set_src(2, 4, 4, 0, 4); cyc_step();
        tj = 1'b1; cyc_step();
        check("tj_drop", drop_out, 3'b110);
        set_src(0, 9, 9, 1, 9); push(9, 9, 1, 9, 0, c + 19);
        cyc_step(); drain(); settle(20);
        clr = 1'b1; cyc_step();
        check("drop_clr", drop_out, 0);

        // ValIn on the same edge as a time jump is discarded
        cyc_step(); set_src(1, 7, 7, 0, 7); tj = 1'b1;
        cyc_step(); settle(25);
        check("tj_same_edge_drop", drop_out, 0);

        // Grant and capture of the same source on one edge
        cyc_step(); set_src(1, 0, 11, 0, 3); c = cyc; push(0, 11, 0, 3, 1, c + 2);
        cyc_step(); set_src(1, 0, 22, 1, 4); push(0, 22, 1, 4, 1, c + 19);
        cyc_step(); drain(); settle(20);
        check("same_edge_ovw", ovw_out, 0);

        // Disabled source ignored; disabling a pending slot drops it
        cyc_step(); en = 3'b110; set_src(0, 8, 8, 0, 8);
        cyc_step(); settle(25);
        en = 3'b111;
        cyc_step(); set_src(0, 12, 12, 0, 12); c = cyc; push(12, 12, 0, 12, 0, c + 2);
        cyc_step(); settle(3);
        set_src(1, 13, 13, 0, 13); cyc_step(); cyc_step();
        en = 3'b101; cyc_step();
        check("dis_drop", drop_out, 3'b010);
        drain(); settle(25);
        en = 3'b111; clr = 1'b1; cyc_step();

        // Reset mid-HOLD with a pending slot
        cyc_step(); set_src(1, 21, 22, 1, 23); c = cyc; push(21, 22, 1, 23, 1, c + 2);
        cyc_step(); drain(); settle(3);
        set_src(2, 31, 32, 0, 33); cyc_step(); cyc_step();
        rst_n = 1'b0; #1;
        check("mid_rst_val", val_out, 0);
        check("mid_rst_grant", grant_out, 0);
        check("mid_rst_count", cnt_out, 0);
        check("mid_rst_sec", sec_out, 0);
        check("mid_rst_ns", ns_out, 0);
        check("mid_rst_sign", sign_out, 0);
        check("mid_rst_intv", intv_out, 0);
        exp_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle(40);
        check("post_rst_count", cnt_out, 0);
        cyc_step(); set_src(2, 41, 42, 1, 43); c = cyc; push(41, 42, 1, 43, 2, c + 2);
        cyc_step(); drain(); settle(3);
        check("post_rst_issue_count", cnt_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/offset_adjustment_arbiter.md
Name: offset_adjustment_arbiter

Overview:
- Shares the adjustable clock's single offset-adjustment input between several offset-correction sources, such as the PPS slave, the TOD slave and the PTP slave.
- Buffers one pending adjustment per source, grants by strict priority and emits one registered adjustment pulse at a time.
- Enforces a guard interval after each pulse so the clock finishes applying a correction before the next one arrives.
- Flushes all pending corrections on a clock time jump.

Parameters:
- NumSources_Gen, 3: number of requesters, range 1..4; index 0 has highest priority.
- HoldCycles_Gen, 16: guard cycles after each issued adjustment, minimum 1.

Ports:
- SysClk_ClkIn  in  1  system clock; all logic on its rising edge.
- SysRstN_RstIn  in  1  asynchronous, active-low reset.
- Enable_DatIn  in  NumSources_Gen  per-source enable mask (quasi-static).
- ClockTime_TimeJump_DatIn  in  1  high for one cycle when clock time was set.
- ClearStatus_EvtIn  in  1  one-cycle pulse; clears sticky status flags.
- SrcOffset_Second_DatIn  in  32*NumSources_Gen  seconds; source i occupies bits [32i+31:32i].
- SrcOffset_Nanosecond_DatIn  in  32*NumSources_Gen  nanoseconds, same packing.
- SrcOffset_Sign_DatIn  in  NumSources_Gen  1 = negative.
- SrcOffset_Interval_DatIn  in  32*NumSources_Gen  adjustment interval, same packing.
- SrcOffset_ValIn  in  NumSources_Gen  one-cycle valid per source.
- OffsetAdjustment_Second_DatOut  out  32  granted seconds.
- OffsetAdjustment_Nanosecond_DatOut  out  32  granted nanoseconds.
- OffsetAdjustment_Sign_DatOut  out  1  granted sign.
- OffsetAdjustment_Interval_DatOut  out  32  granted interval.
- OffsetAdjustment_ValOut  out  1  one-cycle valid.
- Grant_DatOut  out  2  index of the last issued source.
- Overwrite_DatOut  out  NumSources_Gen  sticky: a pending slot was overwritten.
- Dropped_DatOut  out  NumSources_Gen  sticky: a pending slot was flushed by a time jump or disable.
- IssueCount_DatOut  out  32  number of issued adjustments; wraps 0xFFFFFFFF to 0.

Behaviour:
- Reset: all outputs 0, all slots empty, FSM in IDLE, hold counter 0.
- Capture, per source i, at each edge where SrcOffset_ValIn[i]=1 and Enable_DatIn[i]=1:
  - Slot i latches all four fields and is marked pending.
  - If slot i was already pending and is not granted on that same edge, the new data overwrites the old (latest wins) and Overwrite_DatOut[i] is set.
- ValIn with Enable_DatIn[i]=0 is ignored.
- Enable_DatIn[i] falling while slot i is pending: slot cleared, Dropped_DatOut[i] set.
- ClockTime_TimeJump_DatIn=1:
  - All pending slots are cleared; Dropped_DatOut is set for each cleared slot.
  - A ValIn on the same edge is discarded (the flush wins).
  - An ISSUE/HOLD already in progress completes normally.
- FSM:
  - IDLE: if any pending and enabled slot exists, pick the lowest index g. On that edge, register the four fields of slot g onto the outputs, set Grant_DatOut=g and clear slot g. The same-edge ValIn[g] case is defined below. Go to ISSUE.
  - ISSUE: ValOut=1 for exactly this cycle; IssueCount_DatOut increments on the leaving edge; load hold counter with HoldCycles_Gen; go to HOLD.
  - HOLD: decrement once per cycle; at 1 go to IDLE. ValOut is held at 0 for HoldCycles_Gen cycles. Requests keep being captured during HOLD.
- Latency: a ValIn sampled at edge k with the FSM idle gives ValOut high in the cycle after edge k+1. Minimum spacing between ValOut pulses is HoldCycles_Gen+1 cycles.
- Grant and capture on the same edge for the same source: the new data stays pending (the capture wins over the clear); no overwrite flag is set.
- Data outputs hold their last issued value until the next grant; they change only on grant edges.
- Sticky flags:
  - ClearStatus_EvtIn clears all sticky flags.
  - A set event and a clear on the same edge: the set wins.
- Grant_DatOut upper bits are 0 when NumSources_Gen<4.
- Reset asserted mid-HOLD or mid-ISSUE: immediate return to reset values; no pulse is completed.

Test Plan:
- Single request: source 1 pulses Sec=0, Ns=250, Sign=1, Interval=1000 at edge k -> ValOut at the cycle after k+1 with those values, Grant=1, IssueCount=1.
- Priority: sources 0 and 2 pulse on the same edge -> source 0 issued first; source 2 issued exactly 17 cycles later (HoldCycles_Gen=16); IssueCount=2.
- Overwrite: source 2 pulses Ns=100 then Ns=200 during HOLD -> one issue with Ns=200; Overwrite[2]=1; ClearStatus -> Overwrite=0.
- Time jump: sources 1 and 2 pending during HOLD, TimeJump pulse -> no further ValOut; Dropped=3'b110; the current HOLD still ends normally.
- Disable: Enable[0]=0 with a source-0 pulse -> ignored, no ValOut. Enable[1] dropped while slot 1 is pending -> Dropped[1]=1, no issue.
- Reset mid-HOLD with a pending slot -> all outputs 0; after release, no ValOut appears until a new request arrives.
